// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
//   pipe_state_e   : occupancy of a stage, encoded as {s_valid, m_valid}
//   ex_mem_ctrl_t  : EX->MEM control bundle (packed into in_ctrl)
//   ex_mem_data_t  : EX->MEM data bundle (packed into in_data)
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } pipe_state_e;

  // Skid valid without main valid cannot happen.
  localparam logic [1:0] STATE_ILLEGAL = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic [2:0] ls_type;
    logic [4:0] rd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] pc_offset;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [4:0]  rs2;
  } ex_mem_data_t;

  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);  // 12
  localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);  // 101

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter for performance monitoring.
//   clk, rst : clock, async active-high reset (count -> 0)
//   clear    : synchronous clear, wins over enable
//   enable   : count up by one this cycle
//   count    : current value, sticks at all-ones
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         count <= '0;
    else if (clear)                  count <= '0;
    else if (enable && count != '1)  count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with a 2-entry skid buffer.
//   clk, rst            : clock, async active-high reset
//   flush               : kill every held entry (bubble insertion)
//   in_valid/in_ready   : upstream handshake; in_ready comes from a flop
//   in_ctrl/in_data     : bundles from upstream
//   out_valid/out_ready : downstream handshake
//   out_ctrl/out_data   : bundles to downstream; out_ctrl zero when invalid
//   stall_cnt, cnt_clr  : saturating count of stalled output cycles
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = 12,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;
  logic [DATA_W-1:0] m_data, s_data;

  logic              m_valid_n, s_valid_n;
  logic [CTRL_W-1:0] m_ctrl_n, s_ctrl_n;
  logic [DATA_W-1:0] m_data_n, s_data_n;

  pipe_state_e state;
  logic        in_fire, out_fire;

  assign state    = pipe_state_e'({s_valid, m_valid});
  // Ready depends only on the skid flop, never on out_ready.
  assign in_ready = ~s_valid;
  assign in_fire  = in_valid & ~s_valid;
  assign out_fire = m_valid & out_ready;

  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;

  always_comb begin
    m_valid_n = m_valid;
    s_valid_n = s_valid;
    m_ctrl_n  = m_ctrl;
    s_ctrl_n  = s_ctrl;
    m_data_n  = m_data;
    s_data_n  = s_data;
    if (flush) begin
      // Any out_fire this cycle already happened downstream; inputs are dropped.
      m_valid_n = 1'b0;
      s_valid_n = 1'b0;
      m_ctrl_n  = '0;
      s_ctrl_n  = '0;
      if (CLEAR_DATA) begin
        m_data_n = '0;
        s_data_n = '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            m_valid_n = 1'b1;
            m_ctrl_n  = in_ctrl;
            m_data_n  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_ctrl_n = in_ctrl;
            m_data_n = in_data;
          end else if (in_fire) begin
            s_valid_n = 1'b1;
            s_ctrl_n  = in_ctrl;
            s_data_n  = in_data;
          end else if (out_fire) begin
            m_valid_n = 1'b0;
          end
        end
        TWO: begin
          if (out_fire) begin
            m_ctrl_n  = s_ctrl;
            m_data_n  = s_data;
            s_valid_n = 1'b0;
            s_ctrl_n  = '0;
          end
        end
        default: begin
          // Unreachable encoding: fall back to empty.
          m_valid_n = 1'b0;
          s_valid_n = 1'b0;
          m_ctrl_n  = '0;
          s_ctrl_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_ctrl  <= '0;
      s_ctrl  <= '0;
      m_data  <= '0;
      s_data  <= '0;
    end else begin
      m_valid <= m_valid_n;
      s_valid <= s_valid_n;
      m_ctrl  <= m_ctrl_n;
      s_ctrl  <= s_ctrl_n;
      m_data  <= m_data_n;
      s_data  <= s_data_n;
    end
  end

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .enable (m_valid & ~out_ready),
    .count  (stall_cnt)
  );

`ifndef SYNTHESIS
  // Previous-cycle view of the upstream handshake for the stability check.
  logic              p_wait;
  logic [CTRL_W-1:0] p_ctrl;
  logic [DATA_W-1:0] p_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_wait <= 1'b0;
      p_ctrl <= '0;
      p_data <= '0;
    end else begin
      p_wait <= in_valid & ~in_ready & ~flush;
      p_ctrl <= in_ctrl;
      p_data <= in_data;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert ({s_valid, m_valid} != STATE_ILLEGAL)
        else $error("pipe_stage_reg: illegal state 10");
      assert (m_valid || out_ctrl == '0)
        else $error("pipe_stage_reg: out_ctrl nonzero while invalid");
      if (p_wait)
        assert (in_valid && in_ctrl == p_ctrl && in_data == p_data)
          else $error("pipe_stage_reg: upstream changed a stalled input");
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready, cnt_clr;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  // Instance 0: data held on flush, 4-bit counter. Instance 1: data cleared, 8-bit counter.
  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;
  logic [3:0]    stall_cnt0;
  logic [7:0]    stall_cnt1;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .stall_cnt(stall_cnt0), .cnt_clr(cnt_clr));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .stall_cnt(stall_cnt1), .cnt_clr(cnt_clr));

  // Reference: a FIFO of at most two instructions plus the last data shown.
  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] held0, held1;
  int            cnt0, cnt1;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    held0 = '0;
    held1 = '0;
    cnt0  = 0;
    cnt1  = 0;
  endtask

  // Apply one clock edge of the rules to the reference.
  task automatic model_step();
    bit   stalled, ofire, ifire;
    ent_t e;
    stalled = (q.size() > 0) && !out_ready;
    ofire   = (q.size() > 0) && out_ready;
    ifire   = in_valid && (q.size() < 2);
    if (cnt_clr) begin
      cnt0 = 0;
      cnt1 = 0;
    end else if (stalled) begin
      if (cnt0 < 15)  cnt0++;
      if (cnt1 < 255) cnt1++;
    end
    if (flush) begin
      if (q.size() > 0) held0 = q[0].d;
      held1 = '0;
      q.delete();
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) begin
        e.c = in_ctrl;
        e.d = in_data;
        q.push_back(e);
      end
      if (q.size() > 0) begin
        held0 = q[0].d;
        held1 = q[0].d;
      end
    end
  endtask

  task automatic check_all();
    logic          v;
    logic [CW-1:0] c;
    v = q.size() > 0;
    c = v ? q[0].c : '0;
    chk("out_valid0", 32'(out_valid0), 32'(v));
    chk("out_valid1", 32'(out_valid1), 32'(v));
    chk("in_ready0",  32'(in_ready0),  32'(q.size() < 2));
    chk("in_ready1",  32'(in_ready1),  32'(q.size() < 2));
    chk("out_ctrl0",  32'(out_ctrl0),  32'(c));
    chk("out_ctrl1",  32'(out_ctrl1),  32'(c));
    chk("out_data0",  32'(out_data0),  32'(v ? q[0].d : held0));
    chk("out_data1",  32'(out_data1),  32'(v ? q[0].d : held1));
    chk("stall_cnt0", 32'(stall_cnt0), 32'(cnt0));
    chk("stall_cnt1", 32'(stall_cnt1), 32'(cnt1));
  endtask

  // One cycle: drive at negedge, model the edge, check at the next negedge.
  task automatic cyc(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                     input logic ordy, input logic fl, input logic clr);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    cnt_clr   = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic          hold;
    logic          iv, ordy, fl, clr;
    logic [CW-1:0] c;
    logic [DW-1:0] d;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_ctrl = '0; in_data = '0;
    model_reset();
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Reset mid-operation: fill to two entries, then reset between edges.
    cyc(1, 12'h011, 16'h1111, 0, 0, 0);
    cyc(1, 12'h022, 16'h2222, 0, 0, 0);
    cyc(1, 12'h022, 16'h2222, 0, 0, 0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b0;

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) cyc(1, CW'(i), DW'(16'h100 + i), 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);

    // Backpressure: A, B fill both entries; C waits, then drains in order.
    cyc(1, 12'h0AA, 16'hAAAA, 0, 0, 0);
    cyc(1, 12'h0BB, 16'hBBBB, 0, 0, 0);
    cyc(1, 12'h0CC, 16'hCCCC, 0, 0, 0);
    cyc(1, 12'h0CC, 16'hCCCC, 0, 0, 0);
    cyc(1, 12'h0CC, 16'hCCCC, 1, 0, 0);
    cyc(1, 12'h0CC, 16'hCCCC, 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);

    // Flush while full with D offered: D must never appear.
    cyc(1, 12'h0E1, 16'hE1E1, 0, 0, 0);
    cyc(1, 12'h0E2, 16'hE2E2, 0, 0, 0);
    cyc(1, 12'h0DD, 16'hDDDD, 0, 1, 0);
    chk("flush_data_held", 32'(out_data0), 32'h0000E1E1);
    cyc(0, '0, '0, 1, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);

    // Counter saturation, then clear during an ongoing stall.
    cyc(1, 12'h055, 16'h5555, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, '0, '0, 0, 0, 0);
    chk("sat_cnt4", 32'(stall_cnt0), 32'd15);
    chk("cnt8", 32'(stall_cnt1), 32'd20);
    cyc(0, '0, '0, 0, 0, 1);
    chk("clr_cnt4", 32'(stall_cnt0), 32'd0);
    cyc(0, '0, '0, 0, 0, 0);

    // Flush coinciding with out_fire in ONE: entry consumed once, stage empty.
    cyc(0, '0, '0, 1, 1, 0);
    cyc(1, 12'h066, 16'h6666, 1, 0, 0);
    cyc(0, '0, '0, 1, 1, 0);
    chk("flush_ofire_data1", 32'(out_data1), 32'd0);
    cyc(0, '0, '0, 1, 0, 0);

    // Random traffic against the reference.
    hold = 1'b0;
    iv = 1'b0; c = '0; d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        iv = $urandom_range(0, 3) != 0;
        c  = CW'($urandom);
        d  = DW'($urandom);
      end
      ordy = $urandom_range(0, 3) != 0;
      fl   = $urandom_range(0, 19) == 0;
      clr  = $urandom_range(0, 29) == 0;
      hold = iv && (q.size() == 2) && !fl;
      cyc(iv, c, d, ordy, fl, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
